keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Scans a 4x4 passive key matrix by driving one column low at a time and sampling the pulled-up row lines. Snapshots are debounced over whole scans, and each clean key press is delivered as a 4-bit hex code on a valid/ready output. It is the input-side counterpart of the multiplexed seven-segment display driver. Its codes feed the digit registers and the program-entry logic.

## Interface
- `SCAN_DIV`, default 256: clocks each column is driven per scan; must be >= 4.
- `DEBOUNCE_SCANS`, default 4: consecutive agreeing full scans required to accept a press or a release; must be >= 1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `row_in` input 4: row lines, active-low (0 = connected to the driven column), asynchronous.
- `col_drive` output 4: one-hot active-low column strobe; bit c low drives column c.
- `key_code` output 4: code of the accepted key, {col[1:0], row[1:0]}.
- `key_valid` output 1: `key_code` holds an unconsumed press.
- `key_ready` input 1: consumer accepts `key_code` on a cycle where `key_valid` is high.
- `key_held` output 1: debounced "a key is down" level.
- `overrun` output 1: one-cycle pulse when a press is dropped because the output was still full.

## Operation
- `row_in` passes through a 2-flop synchronizer before any use.
- Dwell counter runs 0..SCAN_DIV-1. Column index c runs 0..3 and advances, with wrap, when the dwell counter wraps. `col_drive` = ~(1<<c).
- Sample point: on the cycle where the dwell counter = SCAN_DIV-1, the synchronized rows for column c are stored into snapshot bits [4c+3:4c]. A bit is 1 when the key is pressed, i.e. inverted `row_in`.
- Scan end: the sample point of column 3. The 16-bit snapshot is decoded into d:
  - NONE: no bits set.
  - KEY(k): exactly one bit set; k = bit index = {c, r}.
  - MULTI: two or more bits set.
- The FSM updates only at scan end. It holds a candidate `cand` (4b) and a counter `cnt`.
- IDLE:
  - d=KEY(k): `cand`<=k, `cnt`<=1, go to PRESS_DB.
  - If DEBOUNCE_SCANS=1, go directly to PRESSED instead and emit.
- PRESS_DB:
  - d=KEY(`cand`): `cnt`++. On reaching DEBOUNCE_SCANS, go to PRESSED and emit.
  - Any other d: go to IDLE.
- PRESSED:
  - d=KEY(`cand`): stay.
  - Otherwise (NONE, MULTI, or another key): go to RELEASE_DB with `cnt`<=1. If DEBOUNCE_SCANS=1, go to IDLE.
- RELEASE_DB:
  - d≠KEY(`cand`): `cnt`++. On reaching DEBOUNCE_SCANS, go to IDLE.
  - d=KEY(`cand`): return to PRESSED. This is a bounce; no new emit.
- `key_held` = 1 in PRESSED or RELEASE_DB.
- Emit rules:
  - `key_valid`=0: load `key_code`<=`cand`, set `key_valid`.
  - `key_valid`=1 and `key_ready`=1 in the same cycle: load the new code, `key_valid` stays 1.
  - `key_valid`=1 and `key_ready`=0: discard the new code; `overrun` pulses for 1 cycle.
- Handshake: a transfer occurs at a rising edge with `key_valid`&`key_ready`. `key_valid` clears the next cycle unless an emit coincides. `key_code` is stable while `key_valid`=1.
- Auto-repeat is out of scope; one emit per debounced press.

## Timing
- Reset values:
  - `col_drive`=4'b1110, c=0, dwell counter=0.
  - Snapshot=0, synchronizer flops=1 (released).
  - State=IDLE, `cand`=0, `cnt`=0.
  - `key_code`=0, `key_valid`=0, `key_held`=0, `overrun`=0.
- Reset applied mid-scan or with `key_valid` high returns everything to those values on the next edge; a pending code is lost.
- Scan period = 4*SCAN_DIV clocks.
- A row change is visible at the sample point if it is stable at least 2 clocks before it.
- Press latency: `key_valid` rises 1 clock after the scan end of the DEBOUNCE_SCANS-th consecutive scan showing the key.
- `key_held` rises in the same cycle as that `key_valid` rise and falls 1 clock after the release-debounce scan end.
- `overrun` and emits occur only on scan-end+1 cycles.

## Test plan
- Reset: with `rst_n`=0 for 3 clocks, then all rows released, every output must equal its reset value. With SCAN_DIV=4, `col_drive` must then cycle 1110,1101,1011,0111 every 4 clocks.
- Clean press (SCAN_DIV=4, DEBOUNCE_SCANS=2): hold row 2 low whenever column 1 is driven, with `key_ready`=0. The response must be `key_code`=4'h6 and `key_valid`=1 after the 2nd full scan end, and `key_held`=1. Asserting `key_ready` for 1 cycle must then drop `key_valid`.
- Bounce: toggle the same key every other scan during the press. The response must be no emit until 2 consecutive agreeing scans, then exactly one emit; a 1-scan release glitch while PRESSED must produce no second emit.
- Multi-key: press 4'h0 and 4'hF together. There must be no emit and `key_held`=0. Releasing 4'hF must then give an emit of 4'h0 after 2 scans.
- Overrun: press and release 4'h3, then press 4'hA, with `key_ready`=0 throughout. `key_code` must stay 3 and `overrun` must pulse 1 cycle on the 4'hA accept. A repeat of the sequence with `key_ready`=1 on the accept cycle must give `key_code`=4'hA and `key_valid` held high.
- Reset mid-operation: drop `rst_n` while PRESSED with `key_valid`=1. All outputs must be reset values on the next edge, and `col_drive` must restart from 1110.

Source files
------------

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if
// Key-code output channel of the keypad scanner.
//   key_code  : accepted key, {col[1:0], row[1:0]}
//   key_valid : key_code holds an unconsumed press
//   key_ready : consumer takes key_code when key_valid is high
//   key_held  : debounced "a key is down" level
//   overrun   : one-cycle pulse when a press is dropped because the channel was full
// master = scanner side, slave = consumer side.
interface keypad_matrix_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 passive key matrix one column at a time, debounces whole-scan
// snapshots and delivers one hex code per clean press on a valid/ready channel.
// Ports:
//   clk       : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   row_in    : row lines, active-low, asynchronous to clk
//   col_drive : one-hot active-low column strobe
//   key_if    : key-code output channel (master side)
//
// state        | meaning
// S_IDLE       | no key accepted, waiting for a single-key scan
// S_PRESS_DB   | candidate seen on cnt consecutive scans, not yet accepted
// S_PRESSED    | candidate accepted and emitted, key still down
// S_RELEASE_DB | candidate missing on cnt consecutive scans, release pending
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 256,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     row_in,
    output logic [3:0]                     col_drive,
    keypad_matrix_scanner_if.master        key_if
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_PRESSED,
        S_RELEASE_DB
    } state_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [15:0]   snap_q, snap_d;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    logic          sample, scan_end;
    logic [4:0]    ones;
    logic [3:0]    hit;
    logic          d_key, d_cand;
    logic          emit;
    logic [3:0]    emit_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            dwell_q   <= '0;
            col_q     <= 2'd0;
            snap_q    <= '0;
            state_q   <= S_IDLE;
            cand_q    <= 4'h0;
            cnt_q     <= '0;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            row_s1_q  <= row_in;
            row_s2_q  <= row_s1_q;
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Scan timing and snapshot capture. The decode looks at snap_d so the
    // column-3 rows captured on this very cycle take part in the scan result.
    always_comb begin
        sample   = (dwell_q == DWELL_LAST);
        scan_end = sample && (col_q == 2'd3);
        dwell_d  = sample ? '0 : dwell_q + DW'(1);
        col_d    = sample ? col_q + 2'd1 : col_q;
        snap_d   = snap_q;
        if (sample) begin
            snap_d[{col_q, 2'b00} +: 4] = ~row_s2_q;
        end

        ones = 5'd0;
        hit  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                ones = ones + 5'd1;
                hit  = 4'(i);
            end
        end
        d_key  = (ones == 5'd1);
        d_cand = d_key && (hit == cand_q);
    end

    // Debounce FSM; moves only on scan-end cycles.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = cand_q;
        if (scan_end) begin
            case (state_q)
                S_IDLE: begin
                    if (d_key) begin
                        cand_d    = hit;
                        emit_code = hit;
                        cnt_d     = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = S_PRESSED;
                            emit    = 1'b1;
                        end else begin
                            state_d = S_PRESS_DB;
                        end
                    end
                end
                S_PRESS_DB: begin
                    if (d_cand) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CNT_DONE) begin
                            state_d = S_PRESSED;
                            emit    = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (!d_cand) begin
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE_DB;
                    end
                end
                S_RELEASE_DB: begin
                    if (d_cand) begin
                        state_d = S_PRESSED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CNT_DONE) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output channel: a new press replaces the held code only if the old one
    // is consumed on the same edge; otherwise the new press is dropped.
    always_comb begin
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && key_if.key_ready) begin
            valid_d = 1'b0;
        end
        if (emit) begin
            if (!valid_q || key_if.key_ready) begin
                code_d  = emit_code;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign col_drive        = ~(4'b0001 << col_q);
    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
    assign key_if.key_held  = (state_q == S_PRESSED) || (state_q == S_RELEASE_DB);
    assign key_if.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
// Drives a simulated 4x4 key matrix (keys[] = physical key state, row_in
// derived from col_drive) and checks every output on every cycle against a
// scan-level behavioural model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 2;
    localparam int PERIOD   = 4 * SCAN_DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_drive;
    logic [15:0] keys  = 16'h0000;

    int tests = 0;
    int fails = 0;

    keypad_matrix_scanner_if kif ();

    keypad_matrix_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_if    (kif)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key shorts its row to the driven column.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_drive[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c*4 + r]) row_in[r] = 1'b0;
                end
            end
        end
    end

    // Behavioural model: per-scan decisions from the key set seen in that scan.
    int         m_n;
    bit         m_live = 1'b0;
    bit         m_held;
    int         m_cand, m_run, m_rel;
    logic [3:0] m_code;
    bit         m_valid, m_ovr;
    int         nk, k;
    bit         emit;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n = 0; m_held = 0; m_cand = 0; m_run = 0; m_rel = 0;
            m_code = 4'h0; m_valid = 0; m_ovr = 0; m_live = 1;
        end else if (m_live) begin
            emit = 0;
            if (m_n % PERIOD == PERIOD - 1) begin
                nk = $countones(keys);
                k  = 0;
                for (int i = 15; i >= 0; i--) if (keys[i]) k = i;
                if (!m_held) begin
                    if (nk == 1 && m_run > 0 && k == m_cand) m_run++;
                    else if (m_run > 0)                      m_run = 0;
                    else if (nk == 1) begin m_cand = k; m_run = 1; end
                    if (m_run >= DB) begin m_held = 1; m_rel = 0; emit = 1; end
                end else begin
                    if (nk == 1 && k == m_cand) m_rel = 0;
                    else                        m_rel++;
                    if (m_rel >= DB) begin m_held = 0; m_run = 0; end
                end
            end
            m_ovr = 0;
            if (emit) begin
                if (!m_valid || kif.key_ready) begin
                    m_code  = 4'(m_cand);
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && kif.key_ready) begin
                m_valid = 0;
            end
            m_n++;
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("col_drive", col_drive, 4'hF ^ (4'b0001 << ((m_n / SCAN_DIV) % 4)));
            check("key_code",  kif.key_code, m_code);
            check("key_valid", 4'(kif.key_valid), 4'(m_valid));
            check("key_held",  4'(kif.key_held),  4'(m_held));
            check("overrun",   4'(kif.overrun),   4'(m_ovr));
        end
    end

    task automatic wait_phase(input int p);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((m_n % PERIOD) != p && guard < 2 * PERIOD);
        check("wait_phase", 4'((m_n % PERIOD) == p), 4'd1);
    endtask

    task automatic scans(input int n);
        repeat (n) wait_phase(0);
    endtask

    task automatic consume();
        kif.key_ready = 1'b1;
        @(negedge clk);
        kif.key_ready = 1'b0;
    endtask

    logic [3:0] col_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bit         bounce_pat [6] = '{1, 0, 1, 0, 1, 1};
    int         sel;

    initial begin
        kif.key_ready = 1'b0;
        keys  = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst key_code",  kif.key_code, 4'h0);
        check("rst key_valid", 4'(kif.key_valid), 4'd0);
        check("rst key_held",  4'(kif.key_held), 4'd0);
        check("rst overrun",   4'(kif.overrun), 4'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("col_seq", col_drive, col_tab[i / 4]);
            @(negedge clk);
        end

        // Clean press of key 6 (column 1, row 2).
        wait_phase(0);
        keys = 16'h0040;
        wait_phase(0);
        check("press 1 scan valid", 4'(kif.key_valid), 4'd0);
        wait_phase(0);
        check("press valid", 4'(kif.key_valid), 4'd1);
        check("press code",  kif.key_code, 4'h6);
        check("press held",  4'(kif.key_held), 4'd1);
        consume();
        check("press consumed", 4'(kif.key_valid), 4'd0);
        wait_phase(0);
        keys = 16'h0000;
        scans(3);

        // Bounce on press, then a one-scan release glitch.
        for (int i = 0; i < 6; i++) begin
            keys = bounce_pat[i] ? 16'h0040 : 16'h0000;
            wait_phase(0);
            check("bounce valid", 4'(kif.key_valid), (i == 5) ? 4'd1 : 4'd0);
        end
        check("bounce code", kif.key_code, 4'h6);
        consume();
        wait_phase(0);
        keys = 16'h0000;
        wait_phase(0);
        check("glitch held", 4'(kif.key_held), 4'd1);
        keys = 16'h0040;
        scans(2);
        check("glitch no emit", 4'(kif.key_valid), 4'd0);
        keys = 16'h0000;
        scans(3);
        check("release held", 4'(kif.key_held), 4'd0);

        // Two keys together, then one released.
        keys = 16'h8001;
        scans(3);
        check("multi valid", 4'(kif.key_valid), 4'd0);
        check("multi held",  4'(kif.key_held), 4'd0);
        keys = 16'h0001;
        scans(2);
        check("multi->0 valid", 4'(kif.key_valid), 4'd1);
        check("multi->0 code",  kif.key_code, 4'h0);
        consume();
        wait_phase(0);
        keys = 16'h0000;
        scans(3);

        // Overrun: key 3 left unconsumed, then key A.
        keys = 16'h0008;
        scans(2);
        check("ovr code3", kif.key_code, 4'h3);
        keys = 16'h0000;
        scans(2);
        keys = 16'h0400;
        scans(2);
        check("ovr pulse", 4'(kif.overrun), 4'd1);
        check("ovr keep3", kif.key_code, 4'h3);
        @(negedge clk);
        check("ovr one cycle", 4'(kif.overrun), 4'd0);
        keys = 16'h0000;
        wait_phase(0);
        scans(2);
        keys = 16'h0400;
        wait_phase(0);
        wait_phase(PERIOD - 1);
        kif.key_ready = 1'b1;
        @(negedge clk);
        kif.key_ready = 1'b0;
        check("swap code",  kif.key_code, 4'hA);
        check("swap valid", 4'(kif.key_valid), 4'd1);
        check("swap no ovr", 4'(kif.overrun), 4'd0);

        // Reset while PRESSED with a pending code.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst col",   col_drive, 4'b1110);
        check("mid rst code",  kif.key_code, 4'h0);
        check("mid rst valid", 4'(kif.key_valid), 4'd0);
        check("mid rst held",  4'(kif.key_held), 4'd0);
        rst_n = 1'b1;
        keys  = 16'h0000;

        // Randomized keys and consumer.
        wait_phase(0);
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 5) keys = 16'h0000;
            else if (sel >= 6 && sel <= 8) keys = 16'h0001 << $urandom_range(0, 15);
            else if (sel == 9) keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            for (int c = 0; c < PERIOD; c++) begin
                kif.key_ready = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        kif.key_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
